// File: rtl/cpu_pkg.sv
// Shared definitions for the fetch stage: next-PC select encodings,
// the internal next-PC source tag and the default address constants.
package cpu_pkg;

    // D-stage next-PC select encodings carried on br_sel
    typedef enum logic [1:0] {
        NPC_SEQ = 2'd0,
        NPC_BR  = 2'd1,
        NPC_J   = 2'd2,
        NPC_JR  = 2'd3
    } br_sel_e;

    // Which source actually drove npc this cycle
    typedef enum logic [2:0] {
        SRC_EXC    = 3'd0,
        SRC_ERET   = 3'd1,
        SRC_HOLD   = 3'd2,
        SRC_SEQ    = 3'd3,
        SRC_TARGET = 3'd4
    } npc_src_e;

    localparam logic [31:0] DEF_RESET_PC = 32'h0000_3000;
    localparam logic [31:0] DEF_EXC_VEC  = 32'h0000_4180;
    localparam logic [31:0] DEF_IM_BASE  = 32'h0000_3000;

endpackage

// File: rtl/npc_mux.sv
// Next-PC target computation and priority select for the fetch stage.
// Priority: exception, eret, stall hold, then the D-stage br_sel request.
module npc_mux
    import cpu_pkg::*;
#(
    parameter int              XLEN    = 32,
    parameter logic [XLEN-1:0] EXC_VEC = XLEN'(DEF_EXC_VEC)
) (
    input  logic [XLEN-1:0] pc,
    input  logic            stall,
    input  logic [1:0]      br_sel,
    input  logic            br_taken,
    input  logic [25:0]     imm,
    input  logic [XLEN-1:0] d_pc,
    input  logic [XLEN-1:0] rs_val,
    input  logic            exc_req,
    input  logic            eret_req,
    input  logic [XLEN-1:0] epc,
    output logic [XLEN-1:0] npc,
    output npc_src_e        src
);

    logic [XLEN-1:0] pc_plus4_s;
    logic [XLEN-1:0] d_pc_plus4_s;
    logic [XLEN-1:0] br_off_s;
    logic [XLEN-1:0] br_tgt_s;
    logic [XLEN-1:0] j_tgt_s;

    // Candidate targets, all modulo 2^XLEN
    always_comb begin
        pc_plus4_s   = pc + XLEN'(4);
        d_pc_plus4_s = d_pc + XLEN'(4);
        br_off_s     = {{(XLEN-18){imm[15]}}, imm[15:0], 2'b00};
        br_tgt_s     = d_pc_plus4_s + br_off_s;
        j_tgt_s      = {d_pc_plus4_s[XLEN-1:28], imm, 2'b00};
    end

    // Priority select of the next PC and tagging of its source
    always_comb begin
        npc = pc_plus4_s;
        src = SRC_SEQ;
        if (exc_req) begin
            npc = EXC_VEC;
            src = SRC_EXC;
        end else if (eret_req) begin
            npc = epc;
            src = SRC_ERET;
        end else if (stall) begin
            npc = pc;
            src = SRC_HOLD;
        end else begin
            case (br_sel)
                NPC_BR: begin
                    if (br_taken) begin
                        npc = br_tgt_s;
                        src = SRC_TARGET;
                    end else begin
                        npc = pc_plus4_s;
                        src = SRC_SEQ;
                    end
                end
                NPC_J: begin
                    npc = j_tgt_s;
                    src = SRC_TARGET;
                end
                NPC_JR: begin
                    npc = rs_val;
                    src = SRC_TARGET;
                end
                default: begin
                    npc = pc_plus4_s;
                    src = SRC_SEQ;
                end
            endcase
        end
    end

endmodule

// File: rtl/pc_unit.sv
// Fetch-stage program counter: PC register, delay-slot flag and redirect flag.
// Optional fetch address-error check enabled by defining PC_ADEL_CHECK_EN.
module pc_unit
    import cpu_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEF_RESET_PC),
    parameter logic [XLEN-1:0] EXC_VEC  = XLEN'(DEF_EXC_VEC),
    parameter logic [XLEN-1:0] IM_BASE  = XLEN'(DEF_IM_BASE),
    parameter int              IM_WORDS = 4096
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic [1:0]      br_sel,
    input  logic            br_taken,
    input  logic [25:0]     imm,
    input  logic [XLEN-1:0] d_pc,
    input  logic [XLEN-1:0] rs_val,
    input  logic            exc_req,
    input  logic            eret_req,
    input  logic [XLEN-1:0] epc,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] npc,
    output logic            f_bd,
    output logic            redir,
    output logic            f_adel
);

    logic [XLEN-1:0] pc_d, pc_q;
    logic            f_bd_d, f_bd_q;
    logic            redir_d, redir_q;
    npc_src_e        src_s;

    npc_mux #(
        .XLEN    (XLEN),
        .EXC_VEC (EXC_VEC)
    ) u_npc_mux (
        .pc       (pc_q),
        .stall    (stall),
        .br_sel   (br_sel),
        .br_taken (br_taken),
        .imm      (imm),
        .d_pc     (d_pc),
        .rs_val   (rs_val),
        .exc_req  (exc_req),
        .eret_req (eret_req),
        .epc      (epc),
        .npc      (npc),
        .src      (src_s)
    );

    // Next-state for PC, delay-slot and redirect flags; stall holds both flags
    always_comb begin
        pc_d    = npc;
        f_bd_d  = f_bd_q;
        redir_d = redir_q;
        case (src_s)
            SRC_EXC, SRC_ERET: begin
                f_bd_d  = 1'b0;
                redir_d = 1'b1;
            end
            SRC_HOLD: begin
                f_bd_d  = f_bd_q;
                redir_d = redir_q;
            end
            SRC_TARGET: begin
                f_bd_d  = 1'b1;
                redir_d = 1'b1;
            end
            SRC_SEQ: begin
                f_bd_d  = (br_sel != 2'd0);
                redir_d = 1'b0;
            end
            default: begin
                f_bd_d  = 1'b0;
                redir_d = 1'b0;
            end
        endcase
    end

    // Fetch-stage state registers with asynchronous reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q    <= RESET_PC;
            f_bd_q  <= 1'b0;
            redir_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            f_bd_q  <= f_bd_d;
            redir_q <= redir_d;
        end
    end

    assign pc    = pc_q;
    assign f_bd  = f_bd_q;
    assign redir = redir_q;

`ifdef PC_ADEL_CHECK_EN
    // Window bounds widened by one bit so the upper limit cannot wrap
    localparam logic [XLEN:0] IM_LO = {1'b0, IM_BASE};
    localparam logic [XLEN:0] IM_HI = IM_LO + ((XLEN+1)'(IM_WORDS) << 2);

    // Fetch address error: misaligned or outside the instruction window
    always_comb begin
        f_adel = (pc_q[1:0] != 2'b00)
              || ({1'b0, pc_q} < IM_LO)
              || ({1'b0, pc_q} >= IM_HI);
    end
`else
    assign f_adel = 1'b0;
`endif

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed cases followed by random cycles,
// compared against a behavioural model of the next-PC and flag rules.
module tb_pc_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic [1:0]  br_sel;
    logic        br_taken;
    logic [25:0] imm;
    logic [31:0] d_pc;
    logic [31:0] rs_val;
    logic        exc_req;
    logic        eret_req;
    logic [31:0] epc;
    logic [31:0] pc;
    logic [31:0] npc;
    logic        f_bd;
    logic        redir;
    logic        f_adel;

    int n_vec = 0;
    int n_err = 0;

    // model state
    logic [31:0] m_pc;
    logic        m_bd;
    logic        m_redir;

    always #5 clk = ~clk;

    pc_unit dut (
        .clk      (clk),
        .reset    (reset),
        .stall    (stall),
        .br_sel   (br_sel),
        .br_taken (br_taken),
        .imm      (imm),
        .d_pc     (d_pc),
        .rs_val   (rs_val),
        .exc_req  (exc_req),
        .eret_req (eret_req),
        .epc      (epc),
        .pc       (pc),
        .npc      (npc),
        .f_bd     (f_bd),
        .redir    (redir),
        .f_adel   (f_adel)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic s, input logic [1:0] bs, input logic bt,
                         input logic [25:0] im, input logic [31:0] dp,
                         input logic [31:0] rv, input logic ex, input logic er,
                         input logic [31:0] ep);
        stall = s; br_sel = bs; br_taken = bt; imm = im; d_pc = dp;
        rs_val = rv; exc_req = ex; eret_req = er; epc = ep;
    endtask

    // Expected next PC from the architectural selection rules
    function automatic logic [31:0] model_npc();
        int          off;
        logic [31:0] t;
        if (exc_req)       return 32'h0000_4180;
        if (eret_req)      return epc;
        if (stall)         return m_pc;
        case (br_sel)
            2'd1: begin
                if (br_taken) begin
                    off = $signed(imm[15:0]) * 4;
                    t   = d_pc + 32'd4 + off;
                    return t;
                end
                return m_pc + 32'd4;
            end
            2'd2: return ((d_pc + 32'd4) & 32'hF000_0000) | ({6'd0, imm} * 32'd4);
            2'd3: return rs_val;
            default: return m_pc + 32'd4;
        endcase
    endfunction

    function automatic logic model_adel(input logic [31:0] a);
`ifdef PC_ADEL_CHECK_EN
        return (a % 32'd4 != 32'd0) || (a < 32'h3000) || (a >= 32'h3000 + 32'd4 * 32'd4096);
`else
        return 1'b0 & a[0];
`endif
    endfunction

    // One clock: check npc mid-cycle, update model at the edge, check state after it
    task automatic step();
        logic [31:0] exp_npc;
        logic        hold_only;
        #4;
        exp_npc   = model_npc();
        hold_only = stall && !exc_req && !eret_req;
        chk("npc", npc, exp_npc);
        @(posedge clk);
        #1;
        if (exc_req || eret_req) begin
            m_bd    = 1'b0;
            m_redir = 1'b1;
        end else if (!stall) begin
            m_bd    = (br_sel != 2'd0);
            m_redir = (br_sel == 2'd1 && br_taken) || (br_sel >= 2'd2);
        end
        m_pc = exp_npc;
        chk("pc", pc, m_pc);
        chk("f_bd", {31'd0, f_bd}, {31'd0, m_bd});
        if (!hold_only) chk("redir", {31'd0, redir}, {31'd0, m_redir});
        chk("f_adel", {31'd0, f_adel}, {31'd0, model_adel(m_pc)});
    endtask

    task automatic rand_cycle();
        logic [31:0] rv;
        logic [31:0] ev;
        rv = ($urandom_range(0, 3) == 0) ? $urandom()
             : 32'h3000 + ($urandom_range(0, 4200) << 2) + ($urandom_range(0, 7) == 0 ? 32'd2 : 32'd0);
        ev = 32'h3000 + ($urandom_range(0, 4095) << 2);
        drive($urandom_range(0, 3) == 0, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              26'($urandom()), $urandom(), rv,
              $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0, ev);
        step();
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, 2'd0, 1'b0, 26'd0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0);
        @(posedge clk);
        #1;
        chk("rst_pc", pc, 32'h0000_3000);
        chk("rst_bd", {31'd0, f_bd}, 32'd0);
        chk("rst_redir", {31'd0, redir}, 32'd0);
        chk("rst_adel", {31'd0, f_adel}, {31'd0, model_adel(32'h3000)});
        reset   = 1'b0;
        m_pc    = 32'h0000_3000;
        m_bd    = 1'b0;
        m_redir = 1'b0;

        // sequential fetch
        step();
        chk("seq1", pc, 32'h0000_3004);
        step();
        chk("seq2", pc, 32'h0000_3008);

        // taken branch backwards, then the same branch not taken
        drive(1'b0, 2'd1, 1'b1, 26'h000FFFE, 32'h3010, 32'd0, 1'b0, 1'b0, 32'd0);
        step();
        chk("br_tk_pc", pc, 32'h0000_300C);
        chk("br_tk_redir", {31'd0, redir}, 32'd1);
        drive(1'b0, 2'd1, 1'b0, 26'h000FFFE, 32'h3010, 32'd0, 1'b0, 1'b0, 32'd0);
        step();
        chk("br_nt_bd", {31'd0, f_bd}, 32'd1);
        chk("br_nt_redir", {31'd0, redir}, 32'd0);

        // j and jr
        drive(1'b0, 2'd2, 1'b0, 26'h0000C04, 32'h3000, 32'd0, 1'b0, 1'b0, 32'd0);
        step();
        chk("j_pc", pc, 32'h0000_3010);
        drive(1'b0, 2'd3, 1'b0, 26'd0, 32'd0, 32'h3400, 1'b0, 1'b0, 32'd0);
        step();
        chk("jr_pc", pc, 32'h0000_3400);

        // stall with a taken branch pending, then exception during the stall
        drive(1'b1, 2'd1, 1'b1, 26'h0000010, 32'h3400, 32'd0, 1'b0, 1'b0, 32'd0);
        repeat (3) step();
        chk("stall_pc", pc, 32'h0000_3400);
        exc_req = 1'b1;
        step();
        chk("exc_pc", pc, 32'h0000_4180);
        chk("exc_bd", {31'd0, f_bd}, 32'd0);

        // eret, then both requests together
        drive(1'b0, 2'd1, 1'b1, 26'd0, 32'd0, 32'd0, 1'b0, 1'b1, 32'h3024);
        step();
        chk("eret_pc", pc, 32'h0000_3024);
        drive(1'b0, 2'd0, 1'b0, 26'd0, 32'd0, 32'd0, 1'b1, 1'b1, 32'h3024);
        step();
        chk("both_pc", pc, 32'h0000_4180);

        // fetch address-error boundaries via jr
        drive(1'b0, 2'd3, 1'b0, 26'd0, 32'd0, 32'h3002, 1'b0, 1'b0, 32'd0);
        step();
        drive(1'b0, 2'd3, 1'b0, 26'd0, 32'd0, 32'h2FFC, 1'b0, 1'b0, 32'd0);
        step();
        drive(1'b0, 2'd3, 1'b0, 26'd0, 32'd0, 32'h7000, 1'b0, 1'b0, 32'd0);
        step();
        drive(1'b0, 2'd3, 1'b0, 26'd0, 32'd0, 32'h6FFC, 1'b0, 1'b0, 32'd0);
        step();
        drive(1'b0, 2'd3, 1'b0, 26'd0, 32'd0, 32'h3000, 1'b0, 1'b0, 32'd0);
        step();

        // wrap of pc+4 from all-ones
        drive(1'b0, 2'd3, 1'b0, 26'd0, 32'd0, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'd0);
        step();
        drive(1'b0, 2'd0, 1'b0, 26'd0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0);
        step();
        chk("wrap_pc", pc, 32'h0000_0003);

        // random traffic
        for (int i = 0; i < 300; i++) rand_cycle();

        // asynchronous reset mid-cycle
        #2;
        reset = 1'b1;
        #1;
        chk("arst_pc", pc, 32'h0000_3000);
        chk("arst_bd", {31'd0, f_bd}, 32'd0);
        chk("arst_redir", {31'd0, redir}, 32'd0);
        @(posedge clk);
        #1;
        reset   = 1'b0;
        m_pc    = 32'h0000_3000;
        m_bd    = 1'b0;
        m_redir = 1'b0;
        drive(1'b0, 2'd0, 1'b0, 26'd0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0);
        step();
        chk("post_rst_pc", pc, 32'h0000_3004);
        for (int i = 0; i < 100; i++) rand_cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
